// File: rtl/core_pipe_mem.sv
// Memory-request stage between execute (s2) and writeback (s3): holds one instruction,
// issues the aligned data-memory request and turns misaligned accesses into traps.
module core_pipe_mem #(
    parameter  int XLEN       = 64,
    parameter  int WB_OP_W    = 2,
    parameter  int CSR_OP_W   = 3,
    parameter  int CFU_OP_W   = 3,
    localparam int MEM_ADDR_W = XLEN,
    localparam int MEM_STRB_W = XLEN / 8
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    input  logic                  flush,

    input  logic                  s2_valid,
    output logic                  s2_ready,
    input  logic [XLEN-1:0]       s2_pc,
    input  logic [31:0]           s2_instr,
    input  logic [XLEN-1:0]       s2_wdata,
    input  logic [XLEN-1:0]       s2_store_data,
    input  logic [4:0]            s2_rd,
    input  logic [6:0]            s2_lsu_op,
    input  logic [WB_OP_W-1:0]    s2_wb_op,
    input  logic [CSR_OP_W-1:0]   s2_csr_op,
    input  logic [CFU_OP_W-1:0]   s2_cfu_op,
    input  logic                  s2_trap,

    output logic                  s3_valid,
    input  logic                  s3_ready,
    output logic [XLEN-1:0]       s3_pc,
    output logic [31:0]           s3_instr,
    output logic [XLEN-1:0]       s3_wdata,
    output logic [4:0]            s3_rd,
    output logic [6:0]            s3_lsu_op,
    output logic [WB_OP_W-1:0]    s3_wb_op,
    output logic [CSR_OP_W-1:0]   s3_csr_op,
    output logic [CFU_OP_W-1:0]   s3_cfu_op,
    output logic                  s3_trap,

    output logic                  dmem_req,
    output logic [MEM_ADDR_W-1:0] dmem_addr,
    output logic                  dmem_wen,
    output logic [MEM_STRB_W-1:0] dmem_strb,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_gnt
);

    typedef enum logic [1:0] {EMPTY, REQ, HOLD} state_e;

    state_e                  state_q, state_d;
    logic [XLEN-1:0]         pc_q, wdata_q, addr_q, sdata_q;
    logic [31:0]             instr_q;
    logic [4:0]              rd_q, rd_d;
    logic [6:0]              lsu_q, lsu_d;
    logic [WB_OP_W-1:0]      wb_q;
    logic [CSR_OP_W-1:0]     csr_q;
    logic [CFU_OP_W-1:0]     cfu_q;
    logic                    trap_q, trap_d;
    logic                    wen_q, wen_d;
    logic [MEM_STRB_W-1:0]   strb_q, strb_d, strb_base;
    logic [MEM_ADDR_W-1:0]   addr_d;
    logic [XLEN-1:0]         sdata_d;

    logic op_load, op_store, op_byte, op_half, op_word, op_double;
    logic is_mem, misal, misal_trap, go_req;
    logic handover, e_acc;

    assign op_load   = s2_lsu_op[0];
    assign op_store  = s2_lsu_op[1];
    assign op_byte   = s2_lsu_op[2];
    assign op_half   = s2_lsu_op[3];
    assign op_word   = s2_lsu_op[4];
    assign op_double = s2_lsu_op[5];
    assign is_mem    = op_load || op_store;

    assign misal = (op_half && s2_wdata[0]) ||
                   (op_word && (s2_wdata[1:0] != 2'b00)) ||
                   (op_double && (s2_wdata[2:0] != 3'b000));

    // An upstream trap keeps its own cause; misalignment only reports on clean mem ops.
    assign misal_trap = is_mem && !s2_trap && misal;
    assign go_req     = is_mem && !s2_trap && !misal;

    assign dmem_req = (state_q == REQ) && s3_ready && !flush;
    assign s3_valid = (state_q == REQ)  ? (dmem_req && dmem_gnt) :
                      (state_q == HOLD) ? !flush : 1'b0;
    assign handover = s3_valid && s3_ready;
    assign s2_ready = !flush && ((state_q == EMPTY) || handover);
    assign e_acc    = s2_valid && s2_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        strb_base = '0;
        if (op_byte)        strb_base = 8'h01;
        else if (op_half)   strb_base = 8'h03;
        else if (op_word)   strb_base = 8'h0F;
        else if (op_double) strb_base = 8'hFF;

        rd_d    = misal_trap ? (op_load ? 5'd4 : 5'd6) : s2_rd;
        lsu_d   = misal_trap ? {s2_lsu_op[6:2], 2'b00} : s2_lsu_op;
        trap_d  = s2_trap || misal_trap;
        wen_d   = go_req && op_store;
        strb_d  = wen_d ? (strb_base << s2_wdata[2:0]) : '0;
        addr_d  = {s2_wdata[XLEN-1:3], 3'b000};
        sdata_d = s2_store_data << {s2_wdata[2:0], 3'b000};

        state_d = state_q;
        if (flush)         state_d = EMPTY;
        else if (e_acc)    state_d = go_req ? REQ : HOLD;
        else if (handover) state_d = EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= EMPTY;
            pc_q    <= '0;
            instr_q <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            lsu_q   <= '0;
            wb_q    <= '0;
            csr_q   <= '0;
            cfu_q   <= '0;
            trap_q  <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (e_acc) begin
                pc_q    <= s2_pc;
                instr_q <= s2_instr;
                wdata_q <= s2_wdata;
                rd_q    <= rd_d;
                lsu_q   <= lsu_d;
                wb_q    <= s2_wb_op;
                csr_q   <= s2_csr_op;
                cfu_q   <= s2_cfu_op;
                trap_q  <= trap_d;
                addr_q  <= addr_d;
                wen_q   <= wen_d;
                strb_q  <= strb_d;
                sdata_q <= sdata_d;
            end else if (flush || handover) begin
                // Stage drains: drop write intent so a stale store cannot linger.
                wen_q  <= 1'b0;
                strb_q <= '0;
            end
        end
    end

    assign s3_pc      = pc_q;
    assign s3_instr   = instr_q;
    assign s3_wdata   = wdata_q;
    assign s3_rd      = rd_q;
    assign s3_lsu_op  = lsu_q;
    assign s3_wb_op   = wb_q;
    assign s3_csr_op  = csr_q;
    assign s3_cfu_op  = cfu_q;
    assign s3_trap    = trap_q;
    assign dmem_addr  = addr_q;
    assign dmem_wen   = wen_q;
    assign dmem_strb  = strb_q;
    assign dmem_wdata = sdata_q;

endmodule

// File: doc/core_pipe_mem.md
# core_pipe_mem

Memory-request stage between execute (s2) and writeback (s3). It holds one instruction at a time. For loads and stores it issues the data memory request, with the address aligned to a doubleword, byte strobes and shifted store data. It detects misaligned accesses and converts them into traps, and hands the instruction to writeback in the same cycle the memory grant arrives, so load data returns while the instruction sits in writeback.

## Interface
- XLEN, 64: data width; MEM_ADDR_W = XLEN, MEM_STRB_W = XLEN/8.
- g_clk  in  1  global clock.
- g_reset  in  1  synchronous active-high reset.
- flush  in  1  cancel held instruction (writeback control-flow change taken).
- s2_valid  in  1  execute offers an instruction.
- s2_ready  out  1  stage can accept this cycle.
- s2_pc, s2_instr  in  XLEN, 32  PC and instruction word.
- s2_wdata  in  XLEN  ALU result; effective address for LSU ops.
- s2_store_data  in  XLEN  store data (rs2).
- s2_rd  in  5  destination register, or trap cause when s2_trap.
- s2_lsu_op  in  7  {SEXT, DOUBLE, WORD, HALF, BYTE, STORE, LOAD} one-hot size, LOAD/STORE exclusive.
- s2_wb_op, s2_csr_op, s2_cfu_op  in  codebase widths  forwarded unchanged.
- s2_trap  in  1  upstream trap pending.
- s3_valid  out  1  instruction available to writeback.
- s3_ready  in  1  writeback accepts.
- s3_pc, s3_instr, s3_wdata, s3_rd, s3_lsu_op, s3_wb_op, s3_csr_op, s3_cfu_op, s3_trap  out  as s2  registered payload.
- dmem_req  out  1  memory request.
- dmem_addr  out  XLEN  request address, bits [2:0] zero.
- dmem_wen  out  1  write enable.
- dmem_strb  out  8  byte strobes.
- dmem_wdata  out  XLEN  store data, lane-aligned.
- dmem_gnt  in  1  request accepted (read data valid next cycle).

## Operation
- States: EMPTY, REQ (memory op outstanding), HOLD (ready to hand over).
- Accept: e_acc = s2_valid && s2_ready. The payload is registered. s3_wdata = s2_wdata (full address, so writeback uses bits [2:0] for load alignment).
- Misalignment: misal = HALF&&a[0] | WORD&&a[1:0]!=0 | DOUBLE&&a[2:0]!=0, where a = s2_wdata.
- Next state on accept:
  - mem op && !s2_trap && !misal -> REQ.
  - Otherwise -> HOLD.
  - Misaligned accesses set s3_trap=1 and s3_rd = 4 (load) or 6 (store), and clear LOAD/STORE in s3_lsu_op.
- REQ:
  - dmem_req = s3_ready && !flush.
  - dmem_wen = STORE.
  - dmem_addr = {a[XL:3], 3'b000}.
  - dmem_strb = BYTE: 8'h01<<a[2:0]; HALF: 8'h03<<a[2:0]; WORD: 8'h0F<<a[2:0]; DOUBLE: 8'hFF. All zero for loads.
  - dmem_wdata = s2_store_data << {a[2:0],3'b000}, computed at accept and registered.
  - The request may be withdrawn before grant; s3_ready low withdraws it.
  - s3_valid = dmem_req && dmem_gnt. On grant the instruction is handed over -> EMPTY, or -> next state if a new instruction is accepted in the same cycle.
- HOLD: s3_valid = !flush. s3_valid && s3_ready -> EMPTY or next.
- s2_ready = EMPTY || (s3_valid && s3_ready).
- flush: from REQ or HOLD -> EMPTY. s3_valid and dmem_req are suppressed in that cycle. flush overrides a simultaneous s2 accept (s2_ready forced 0).

## Timing
- Reset values:
  - state EMPTY, s2_ready=1, s3_valid=0, dmem_req=0, dmem_wen=0.
  - dmem_strb=0, all payload registers 0.
- Latency:
  - non-memory or trapping instruction: accept cycle N, s3_valid at N+1.
  - memory op: dmem_req at N+1; handover in the grant cycle.
- Throughput: one instruction per cycle when s3_ready is high and grants are immediate.
- dmem_* outputs are stable while in REQ. They change only on accept, handover or flush.
- Reset mid-REQ: dmem_req drops in the cycle after g_reset is sampled; no handover occurs.

## Test plan
- ADD at address-free op, s3_ready=1: accept cycle 0 -> s3_valid cycle 1, s3_wdata = s2_wdata, dmem_req never high.
- SW a=0x1004, data 0xDEADBEEF, gnt on the first request cycle:
  - dmem_addr = 0x1000, strb = 8'hF0, wdata[63:32] = 0xDEADBEEF, wen=1.
  - s3_valid in the gnt cycle.
- LH a=0x2003 -> no dmem_req; s3_trap=1, s3_rd=4, s3_lsu_op LOAD=0, s3_valid next cycle.
- LD a=0x3000 with gnt delayed 3 cycles and s3_ready toggling:
  - dmem_req follows s3_ready, addr held at 0x3000, strb 0.
  - Exactly one handover, and s2_ready stays low until it.
- flush while in REQ with dmem_gnt=1 same cycle -> dmem_req=0, s3_valid=0, state EMPTY next cycle; flush in HOLD -> no handover.
- Back-to-back LB/SB stream with immediate grants -> one handover per cycle. Assert g_reset mid-stream -> all outputs return to reset values the following cycle.
